// File: rtl/transport_ctrl.sv
// Transport sequencer: play/pause/stop FSM, BPM register, step/beat/measure tick generation.
// Latency: ticks registered, one cycle after the counter wraps; BPM-to-period divide takes 32 cycles.
// Backpressure: none; single-cycle request pulses are always accepted.
module transport_ctrl #(
    parameter int CLK_HZ            = 50_000_000,
    parameter int STEPS_PER_BEAT    = 4,
    parameter int BEATS_PER_MEASURE = 4,
    parameter int BPM_MIN           = 20,
    parameter int BPM_MAX           = 240,
    parameter int BPM_RESET         = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play_pulse,
    input  logic       stop_pulse,
    input  logic       count_in_en,
    input  logic       bpm_up,
    input  logic       bpm_down,
    input  logic       bpm_load,
    input  logic [7:0] bpm_in,
    output logic       is_playing,
    output logic [7:0] bpm,
    output logic [1:0] state,
    output logic       step_tick,
    output logic       beat_tick,
    output logic       measure_tick,
    output logic       count_click,
    output logic [7:0] step_idx,
    output logic [7:0] beat_idx,
    output logic       div_busy
);

    localparam int          SPB_LG       = $clog2(STEPS_PER_BEAT);
    localparam logic [7:0]  STEPS_LAST   = 8'(STEPS_PER_BEAT * BEATS_PER_MEASURE - 1);
    localparam logic [7:0]  BEAT_MASK    = 8'(STEPS_PER_BEAT - 1);
    localparam logic [63:0] DIVIDEND_W   = 64'(CLK_HZ) * 64'd60;
    localparam logic [31:0] DIVIDEND     = DIVIDEND_W[31:0];
    localparam logic [31:0] PERIOD_RESET = 32'(DIVIDEND_W / 64'(BPM_RESET * STEPS_PER_BEAT));
    localparam logic [7:0]  BPM_MIN_B    = 8'(BPM_MIN);
    localparam logic [7:0]  BPM_MAX_B    = 8'(BPM_MAX);
    localparam logic [7:0]  BPM_RESET_B  = 8'(BPM_RESET);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_COUNT_IN = 2'd1,
        ST_PLAYING  = 2'd2,
        ST_PAUSED   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  bpm_q, bpm_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  step_q, step_d;
    logic [7:0]  cin_q, cin_d;
    logic        step_tick_q, step_tick_d;
    logic        beat_tick_q, beat_tick_d;
    logic        measure_tick_q, measure_tick_d;
    logic        click_q, click_d;
    logic        busy_q, busy_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [31:0] div_rem_q, div_rem_d;
    logic [31:0] div_quo_q, div_quo_d;
    logic [31:0] div_dvsr_q, div_dvsr_d;

    logic        fire;
    logic [31:0] cnt_run;
    logic [7:0]  step_nx;
    logic [7:0]  cin_nx;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_STOPPED;
            bpm_q          <= BPM_RESET_B;
            period_q       <= PERIOD_RESET;
            cnt_q          <= '0;
            step_q         <= '0;
            cin_q          <= '0;
            step_tick_q    <= 1'b0;
            beat_tick_q    <= 1'b0;
            measure_tick_q <= 1'b0;
            click_q        <= 1'b0;
            busy_q         <= 1'b0;
            div_cnt_q      <= '0;
            div_rem_q      <= '0;
            div_quo_q      <= '0;
            div_dvsr_q     <= '0;
        end else begin
            state_q        <= state_d;
            bpm_q          <= bpm_d;
            period_q       <= period_d;
            cnt_q          <= cnt_d;
            step_q         <= step_d;
            cin_q          <= cin_d;
            step_tick_q    <= step_tick_d;
            beat_tick_q    <= beat_tick_d;
            measure_tick_q <= measure_tick_d;
            click_q        <= click_d;
            busy_q         <= busy_d;
            div_cnt_q      <= div_cnt_d;
            div_rem_q      <= div_rem_d;
            div_quo_q      <= div_quo_d;
            div_dvsr_q     <= div_dvsr_d;
        end
    end

    // BPM register and the restoring divider that turns it into a step period.
    always_comb begin
        bpm_d      = bpm_q;
        period_d   = period_q;
        busy_d     = busy_q;
        div_cnt_d  = div_cnt_q;
        div_rem_d  = div_rem_q;
        div_quo_d  = div_quo_q;
        div_dvsr_d = div_dvsr_q;

        if (bpm_load) begin
            if (bpm_in < BPM_MIN_B)      bpm_d = BPM_MIN_B;
            else if (bpm_in > BPM_MAX_B) bpm_d = BPM_MAX_B;
            else                         bpm_d = bpm_in;
        end else if (bpm_up && !bpm_down) begin
            if (bpm_q < BPM_MAX_B) bpm_d = bpm_q + 8'd1;
        end else if (bpm_down && !bpm_up) begin
            if (bpm_q > BPM_MIN_B) bpm_d = bpm_q - 8'd1;
        end

        rem_sh  = {div_rem_q, div_quo_q[31]};
        rem_ge  = rem_sh >= {1'b0, div_dvsr_q};
        rem_sub = rem_sh[31:0] - div_dvsr_q;

        if (bpm_d != bpm_q) begin
            busy_d     = 1'b1;
            div_cnt_d  = '0;
            div_rem_d  = '0;
            div_quo_d  = DIVIDEND;
            div_dvsr_d = 32'(bpm_d) << SPB_LG;
        end else if (busy_q) begin
            div_rem_d = rem_ge ? rem_sub : rem_sh[31:0];
            div_quo_d = {div_quo_q[30:0], rem_ge};
            div_cnt_d = div_cnt_q + 5'd1;
            if (div_cnt_q == 5'd31) begin
                busy_d   = 1'b0;
                period_d = {div_quo_q[30:0], rem_ge};
            end
        end
    end

    // Transport FSM and step timing; >= compare lets a shrinking period fire at once.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        step_d         = step_q;
        cin_d          = cin_q;
        step_tick_d    = 1'b0;
        beat_tick_d    = 1'b0;
        measure_tick_d = 1'b0;
        click_d        = 1'b0;

        fire    = cnt_q >= (period_q - 32'd1);
        cnt_run = fire ? 32'd0 : cnt_q + 32'd1;
        step_nx = (step_q == STEPS_LAST) ? 8'd0 : step_q + 8'd1;
        cin_nx  = cin_q + 8'd1;

        if (stop_pulse) begin
            state_d = ST_STOPPED;
            cnt_d   = '0;
            step_d  = '0;
            cin_d   = '0;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    if (play_pulse) begin
                        cnt_d  = '0;
                        step_d = '0;
                        cin_d  = '0;
                        if (count_in_en) begin
                            state_d = ST_COUNT_IN;
                            click_d = 1'b1;
                        end else begin
                            state_d        = ST_PLAYING;
                            step_tick_d    = 1'b1;
                            beat_tick_d    = 1'b1;
                            measure_tick_d = 1'b1;
                        end
                    end
                end
                ST_COUNT_IN: begin
                    cnt_d = cnt_run;
                    if (fire) begin
                        if (cin_q == STEPS_LAST) begin
                            state_d        = ST_PLAYING;
                            cin_d          = '0;
                            step_d         = '0;
                            step_tick_d    = 1'b1;
                            beat_tick_d    = 1'b1;
                            measure_tick_d = 1'b1;
                        end else begin
                            cin_d   = cin_nx;
                            click_d = (cin_nx & BEAT_MASK) == 8'd0;
                        end
                    end
                end
                ST_PLAYING: begin
                    if (play_pulse) begin
                        state_d = ST_PAUSED;
                    end else begin
                        cnt_d = cnt_run;
                        if (fire) begin
                            step_d         = step_nx;
                            step_tick_d    = 1'b1;
                            beat_tick_d    = (step_nx & BEAT_MASK) == 8'd0;
                            measure_tick_d = step_nx == 8'd0;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (play_pulse) state_d = ST_PLAYING;
                end
                default: state_d = ST_STOPPED;
            endcase
        end
    end

    assign is_playing   = (state_q == ST_PLAYING);
    assign bpm          = bpm_q;
    assign state        = state_q;
    assign step_tick    = step_tick_q;
    assign beat_tick    = beat_tick_q;
    assign measure_tick = measure_tick_q;
    assign count_click  = click_q;
    assign step_idx     = step_q;
    assign beat_idx     = step_q >> SPB_LG;
    assign div_busy     = busy_q;

endmodule
